// File: rtl/ddr_util_report.sv
// Per-run DDR utilization report: samples the usage counters after net_finish and
// converts them to per-mille busy/sub-class ratios on one shared restoring divider.
//
// state      | meaning
// IDLE       | waiting for a delayed net_finish rising edge
// LOAD       | set up numerator use_part*SCALE, divisor total
// DIV_BUSY   | NW-cycle division for the busy ratio
// DIV_SUB    | NW-cycle division for the sub-class ratio
// DONE       | report outputs valid, result_valid high
module ddr_util_report #(
    parameter int CNT_W = 32,
    parameter int SCALE = 1000,
    parameter int RUN_W = 16
) (
    input  logic             ddr_usr_clk,
    input  logic             sys_rst_n,
    input  logic             net_finish,
    input  logic [CNT_W-1:0] use_part,
    input  logic [CNT_W-1:0] use_wr_part,
    input  logic [CNT_W-1:0] unuse_part,
    input  logic             stat_clr,
    output logic             busy,
    output logic             result_valid,
    output logic [9:0]       busy_pml,
    output logic [9:0]       sub_pml,
    output logic [9:0]       max_busy_pml,
    output logic [9:0]       min_busy_pml,
    output logic [RUN_W-1:0] run_cnt,
    output logic             overrun
);

    localparam int NW = CNT_W + 10;
    localparam int TW = CNT_W + 1;
    localparam int RW = CNT_W + 2;
    localparam int CW = $clog2(NW);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_DIV_BUSY = 3'd2;
    localparam logic [2:0] S_DIV_SUB  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       state;
    logic [3:0]       fin_dl;
    logic             trig;
    logic [CNT_W-1:0] use_q;
    logic [CNT_W-1:0] wr_q;
    logic [TW-1:0]    total_q;
    logic [NW-1:0]    num_q;
    logic [RW-1:0]    rem_q;
    logic [9:0]       quo_q;
    logic [9:0]       quo_busy_q;
    logic [CW-1:0]    bit_cnt;

    logic [RW-1:0]    rem_sh;
    logic [RW-1:0]    rem_nxt;
    logic             q_bit;
    logic [9:0]       quo_nxt;
    logic             div_last;
    logic             sub_last;

    logic [RUN_W-1:0] run_base;
    logic [9:0]       max_base;
    logic [9:0]       min_base;

    // fin_dl[3] is the previous value of stage 3, used only for edge detection
    assign trig     = fin_dl[2] & ~fin_dl[3];
    assign busy     = (state != S_IDLE);
    assign div_last = (bit_cnt == '0);
    assign sub_last = (state == S_DIV_SUB) && div_last;

    // A zero divisor forces every quotient bit to 0 so the ratio reads 0
    always_comb begin
        rem_sh  = {rem_q[RW-2:0], num_q[NW-1]};
        q_bit   = (total_q != '0) && (rem_sh >= {1'b0, total_q});
        rem_nxt = q_bit ? (rem_sh - {1'b0, total_q}) : rem_sh;
        quo_nxt = {quo_q[8:0], q_bit};
    end

    always_comb begin
        run_base = stat_clr ? '0 : run_cnt;
        max_base = stat_clr ? '0 : max_busy_pml;
        min_base = stat_clr ? 10'h3FF : min_busy_pml;
    end

    always_ff @(posedge ddr_usr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fin_dl <= '0;
        end else begin
            fin_dl <= {fin_dl[2:0], net_finish};
        end
    end

    always_ff @(posedge ddr_usr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            use_q      <= '0;
            wr_q       <= '0;
            total_q    <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            quo_busy_q <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        use_q   <= use_part;
                        wr_q    <= use_wr_part;
                        total_q <= {1'b0, use_part} + {1'b0, unuse_part};
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    num_q   <= NW'(use_q) * NW'(SCALE);
                    rem_q   <= '0;
                    quo_q   <= '0;
                    bit_cnt <= CW'(NW - 1);
                    state   <= S_DIV_BUSY;
                end
                S_DIV_BUSY, S_DIV_SUB: begin
                    num_q   <= {num_q[NW-2:0], 1'b0};
                    rem_q   <= rem_nxt;
                    quo_q   <= quo_nxt;
                    bit_cnt <= bit_cnt - CW'(1);
                    if (div_last) begin
                        if (state == S_DIV_BUSY) begin
                            quo_busy_q <= quo_nxt;
                            num_q      <= NW'(wr_q) * NW'(SCALE);
                            rem_q      <= '0;
                            quo_q      <= '0;
                            bit_cnt    <= CW'(NW - 1);
                            state      <= S_DIV_SUB;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Report registers are written on the edge entering DONE so they are valid with result_valid
    always_ff @(posedge ddr_usr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            result_valid <= 1'b0;
            busy_pml     <= '0;
            sub_pml      <= '0;
            run_cnt      <= '0;
            max_busy_pml <= '0;
            min_busy_pml <= 10'h3FF;
        end else begin
            result_valid <= sub_last;
            if (sub_last) begin
                busy_pml     <= quo_busy_q;
                sub_pml      <= quo_nxt;
                run_cnt      <= (&run_base) ? run_base : run_base + RUN_W'(1);
                max_busy_pml <= (quo_busy_q > max_base) ? quo_busy_q : max_base;
                min_busy_pml <= (quo_busy_q < min_base) ? quo_busy_q : min_base;
            end else if (stat_clr && (state == S_DONE)) begin
                // clear coinciding with the report keeps this run as the only sample
                run_cnt      <= RUN_W'(1);
                max_busy_pml <= busy_pml;
                min_busy_pml <= busy_pml;
            end else if (stat_clr) begin
                run_cnt      <= '0;
                max_busy_pml <= '0;
                min_busy_pml <= 10'h3FF;
            end
        end
    end

    always_ff @(posedge ddr_usr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overrun <= 1'b0;
        end else if (trig && busy) begin
            overrun <= 1'b1;
        end else if (stat_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr_util_report.sv
// Randomized scoreboard bench for ddr_util_report; a second instance with RUN_W=2
// shares all stimulus to exercise run counter saturation.
module tb_ddr_util_report;

    logic        ddr_usr_clk = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        net_finish  = 1'b0;
    logic        stat_clr    = 1'b0;
    logic [31:0] use_part    = '0;
    logic [31:0] use_wr_part = '0;
    logic [31:0] unuse_part  = '0;

    logic        busy, result_valid, overrun;
    logic [9:0]  busy_pml, sub_pml, max_busy_pml, min_busy_pml;
    logic [15:0] run_cnt;

    logic        busy2, result_valid2, overrun2;
    logic [9:0]  busy_pml2, sub_pml2, max_busy_pml2, min_busy_pml2;
    logic [1:0]  run_cnt2;

    ddr_util_report #(.CNT_W(32), .SCALE(1000), .RUN_W(16)) dut (
        .ddr_usr_clk(ddr_usr_clk), .sys_rst_n(sys_rst_n), .net_finish(net_finish),
        .use_part(use_part), .use_wr_part(use_wr_part), .unuse_part(unuse_part),
        .stat_clr(stat_clr), .busy(busy), .result_valid(result_valid),
        .busy_pml(busy_pml), .sub_pml(sub_pml), .max_busy_pml(max_busy_pml),
        .min_busy_pml(min_busy_pml), .run_cnt(run_cnt), .overrun(overrun)
    );

    ddr_util_report #(.CNT_W(32), .SCALE(1000), .RUN_W(2)) dut_sat (
        .ddr_usr_clk(ddr_usr_clk), .sys_rst_n(sys_rst_n), .net_finish(net_finish),
        .use_part(use_part), .use_wr_part(use_wr_part), .unuse_part(unuse_part),
        .stat_clr(stat_clr), .busy(busy2), .result_valid(result_valid2),
        .busy_pml(busy_pml2), .sub_pml(sub_pml2), .max_busy_pml(max_busy_pml2),
        .min_busy_pml(min_busy_pml2), .run_cnt(run_cnt2), .overrun(overrun2)
    );

    always #5 ddr_usr_clk = ~ddr_usr_clk;

    int cyc = 0;
    always @(posedge ddr_usr_clk) cyc <= cyc + 1;

    typedef struct {
        int busy;
        int sub;
        int exp_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int n_cmp = 0;
    int n_err = 0;

    int m_run, m_run2, m_max, m_min, m_busy, m_sub;
    bit m_over;
    bit prev_rv = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ratio: plain integer arithmetic on 64-bit values
    function automatic int pml(input longint unsigned num, input longint unsigned tot);
        if (tot == 0) return 0;
        return int'((num * 64'd1000) / tot);
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_run2 = 0;
        m_max  = 0;
        m_min  = 1023;
        m_busy = 0;
        m_sub  = 0;
        m_over = 1'b0;
        sb.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ddr_usr_clk);
            #2;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports, owns the statistics model
    always @(negedge ddr_usr_clk) begin
        if (!sys_rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if (prev_rv) begin
                chk("rv_single_cycle", result_valid, 0);
                chk("busy_falls_after_rv", busy, 0);
            end
            if (result_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rv: got result_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e_mon  = sb.pop_front();
                    m_busy = e_mon.busy;
                    m_sub  = e_mon.sub;
                    if (m_run < 65535) m_run++;
                    if (m_run2 < 3) m_run2++;
                    if (e_mon.busy > m_max) m_max = e_mon.busy;
                    if (e_mon.busy < m_min) m_min = e_mon.busy;
                    chk("latency_cycle", cyc, e_mon.exp_cyc);
                    chk("busy_pml", busy_pml, m_busy);
                    chk("sub_pml", sub_pml, m_sub);
                    chk("max_busy_pml", max_busy_pml, m_max);
                    chk("min_busy_pml", min_busy_pml, m_min);
                    chk("run_cnt", run_cnt, m_run);
                    chk("run_cnt_sat2", run_cnt2, m_run2);
                    chk("overrun", overrun, m_over);
                    chk("busy_in_done", busy, 1);
                end
            end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missing_rv: got no result_valid, expected one at cycle %0d", sb[0].exp_cyc);
                void'(sb.pop_front());
            end
            if (stat_clr) begin
                m_over = 1'b0;
                if (result_valid) begin
                    m_run  = 1;
                    m_run2 = 1;
                    m_max  = m_busy;
                    m_min  = m_busy;
                end else begin
                    m_run  = 0;
                    m_run2 = 0;
                    m_max  = 0;
                    m_min  = 1023;
                end
            end
            prev_rv = result_valid;
        end
    end

    // One report: counters held from launch; optional stat_clr at cycle c+clr_off and
    // optional second net_finish edge landing on T+40 with altered counters.
    task automatic run_report(input longint unsigned u, input longint unsigned un,
                              input longint unsigned w, input int clr_off, input bit ovl);
        int c;
        exp_t e;
        bit done;
        use_part    = u[31:0];
        unuse_part  = un[31:0];
        use_wr_part = w[31:0];
        c = cyc;
        e.busy    = pml(u, u + un);
        e.sub     = pml(w, u + un);
        e.exp_cyc = c + 89;
        sb.push_back(e);
        net_finish = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick(1);
            net_finish = (cyc < c + 2) || (ovl && cyc >= c + 40 && cyc < c + 42);
            stat_clr   = (clr_off > 0) && (cyc == c + clr_off);
            if (ovl && cyc == c + 40) begin
                use_part    = $urandom;
                unuse_part  = $urandom;
                use_wr_part = $urandom;
            end
            if (ovl && cyc == c + 44) m_over = 1'b1;
            if (sb.size() == 0 && cyc > c + clr_off && cyc > c + 45) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL report_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        stat_clr   = 1'b0;
        net_finish = 1'b0;
        tick(4);
    endtask

    task automatic chk_cleared_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_busy_pml"}, busy_pml, 0);
        chk({tag, "_sub_pml"}, sub_pml, 0);
        chk({tag, "_max"}, max_busy_pml, 0);
        chk({tag, "_min"}, min_busy_pml, 10'h3FF);
        chk({tag, "_run_cnt"}, run_cnt, 0);
        chk({tag, "_run_cnt_sat2"}, run_cnt2, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int c;
        longint unsigned u, un, w;
        int sh;
        model_reset();
        repeat (3) @(posedge ddr_usr_clk);
        @(negedge ddr_usr_clk);
        sys_rst_n = 1'b1;
        tick(2);
        chk_cleared_state("reset");

        run_report(750, 250, 300, 0, 1'b0);
        run_report(1, 2, 1, 0, 1'b0);
        run_report(64'hFFFF_FFFF, 0, 0, 0, 1'b0);
        run_report(0, 0, 0, 0, 1'b0);
        run_report(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 1'b0);

        // Overlapping trigger, then a standalone clear
        run_report(600, 400, 100, 0, 1'b1);
        tick(100);
        chk("overrun_sticky", overrun, 1);
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        chk("clr_overrun", overrun, 0);
        chk("clr_run_cnt", run_cnt, 0);
        chk("clr_min", min_busy_pml, 10'h3FF);
        chk("clr_max", max_busy_pml, 0);
        chk("clr_keeps_busy_pml", busy_pml, m_busy);
        chk("clr_keeps_sub_pml", sub_pml, m_sub);

        // Clear on the result_valid cycle, and on the cycle before it
        run_report(500, 500, 123, 89, 1'b0);
        run_report(900, 100, 450, 88, 1'b0);

        // Reset in the middle of a computation
        use_part    = 32'd700;
        unuse_part  = 32'd300;
        use_wr_part = 32'd10;
        c = cyc;
        net_finish = 1'b1;
        tick(2);
        net_finish = 1'b0;
        while (cyc < c + 33) tick(1);
        sys_rst_n = 1'b0;
        #1;
        chk_cleared_state("midrun_reset");
        model_reset();
        @(negedge ddr_usr_clk);
        sys_rst_n = 1'b1;
        tick(100);
        chk("no_rv_after_reset_run_cnt", run_cnt, 0);

        for (int i = 0; i < 30; i++) begin
            sh = $urandom_range(0, 32);
            u  = (sh == 32) ? 64'd0 : longint'($urandom >> sh);
            sh = $urandom_range(0, 32);
            un = (sh == 32) ? 64'd0 : longint'($urandom >> sh);
            w  = (u == 0) ? 64'd0 : longint'($urandom) % (u + 1);
            run_report(u, un, w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 95)) : 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no completion, expected finish before 1ms");
        $fatal(1, "bench timeout");
    end

endmodule
